// File: rtl/pipeline_pkg.sv
// Shared encodings for the MIPS pipeline: ALUOP, funct and ALU control codes,
// plus the bit positions inside the packed wb/m control fields.
package pipeline_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALUCTL_AND   = 3'b000;
  localparam logic [2:0] ALUCTL_OR    = 3'b001;
  localparam logic [2:0] ALUCTL_ADD   = 3'b010;
  localparam logic [2:0] ALUCTL_PASS0 = 3'b011;
  localparam logic [2:0] ALUCTL_SUB   = 3'b110;
  localparam logic [2:0] ALUCTL_SLT   = 3'b111;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  localparam int M_BRANCH    = 2;
  localparam int M_MEMREAD   = 1;
  localparam int M_MEMWRITE  = 0;

endpackage

// File: rtl/alu.sv
// Combinational ALU for the execute stage; unknown control codes yield 0.
module alu
  import pipeline_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [2:0]    alu_ctl,
  output logic [DW-1:0] result,
  output logic          zero
);

  always_comb begin
    result = '0;
    case (alu_ctl)
      ALUCTL_AND: result = a & b;
      ALUCTL_OR:  result = a | b;
      ALUCTL_ADD: result = a + b;
      ALUCTL_SUB: result = a - b;
      ALUCTL_SLT: result = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
      default:    result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/iexecute.sv
// MIPS execute stage: ALU control decode, operand/destination muxes, branch
// target adder and the EX/MEM pipeline register.
module iexecute
  import pipeline_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  input  logic [1:0]    wb_ctl,
  input  logic [2:0]    m_ctl,
  input  logic          regdst,
  input  logic          alusrc,
  input  logic [1:0]    aluop,
  input  logic [DW-1:0] npc,
  input  logic [DW-1:0] rdata1,
  input  logic [DW-1:0] rdata2,
  input  logic [DW-1:0] s_extend,
  input  logic [RW-1:0] instr_2016,
  input  logic [RW-1:0] instr_1511,
  output logic [1:0]    wb_ctlout,
  output logic          branch,
  output logic          memread,
  output logic          memwrite,
  output logic [DW-1:0] add_result,
  output logic          zero,
  output logic [DW-1:0] alu_result,
  output logic [DW-1:0] rdata2out,
  output logic [RW-1:0] muxout,
  output logic          pcsrc
);

  logic [2:0]    alu_ctl;
  logic [DW-1:0] alu_b;
  logic [DW-1:0] alu_res;
  logic          alu_zero;
  logic [DW-1:0] target;
  logic [RW-1:0] dest;

  always_comb begin
    alu_ctl = ALUCTL_PASS0;
    case (aluop)
      ALUOP_ADD: alu_ctl = ALUCTL_ADD;
      ALUOP_SUB: alu_ctl = ALUCTL_SUB;
      ALUOP_RTYPE: begin
        case (s_extend[5:0])
          FUNCT_ADD: alu_ctl = ALUCTL_ADD;
          FUNCT_SUB: alu_ctl = ALUCTL_SUB;
          FUNCT_AND: alu_ctl = ALUCTL_AND;
          FUNCT_OR:  alu_ctl = ALUCTL_OR;
          FUNCT_SLT: alu_ctl = ALUCTL_SLT;
          default:   alu_ctl = ALUCTL_PASS0;
        endcase
      end
      default: alu_ctl = ALUCTL_PASS0;
    endcase
  end

  assign alu_b  = alusrc ? s_extend : rdata2;
  assign target = npc + (s_extend << 2);
  assign dest   = regdst ? instr_1511 : instr_2016;

  alu #(.DW(DW)) u_alu (
    .a       (rdata1),
    .b       (alu_b),
    .alu_ctl (alu_ctl),
    .result  (alu_res),
    .zero    (alu_zero)
  );

  // Flush clears the datapath too so a bubble is fully deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ctlout  <= '0;
      branch     <= 1'b0;
      memread    <= 1'b0;
      memwrite   <= 1'b0;
      add_result <= '0;
      zero       <= 1'b0;
      alu_result <= '0;
      rdata2out  <= '0;
      muxout     <= '0;
      pcsrc      <= 1'b0;
    end else if (flush) begin
      wb_ctlout  <= '0;
      branch     <= 1'b0;
      memread    <= 1'b0;
      memwrite   <= 1'b0;
      add_result <= '0;
      zero       <= 1'b0;
      alu_result <= '0;
      rdata2out  <= '0;
      muxout     <= '0;
      pcsrc      <= 1'b0;
    end else if (!stall) begin
      wb_ctlout  <= {wb_ctl[WB_REGWRITE], wb_ctl[WB_MEMTOREG]};
      branch     <= m_ctl[M_BRANCH];
      memread    <= m_ctl[M_MEMREAD];
      memwrite   <= m_ctl[M_MEMWRITE];
      add_result <= target;
      zero       <= alu_zero;
      alu_result <= alu_res;
      rdata2out  <= rdata2;
      muxout     <= dest;
      pcsrc      <= m_ctl[M_BRANCH] & alu_zero;
    end
  end

endmodule

// File: tb/tb_iexecute.sv
// Directed bench for the execute stage: hand-computed vectors checked one
// cycle after each load, plus reset, stall and flush behaviour.
module tb_iexecute;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush;
  logic [1:0]  wb_ctl;
  logic [2:0]  m_ctl;
  logic        regdst, alusrc;
  logic [1:0]  aluop;
  logic [31:0] npc, rdata1, rdata2, s_extend;
  logic [4:0]  instr_2016, instr_1511;
  logic [1:0]  wb_ctlout;
  logic        branch, memread, memwrite, zero, pcsrc;
  logic [31:0] add_result, alu_result, rdata2out;
  logic [4:0]  muxout;

  int n_checks = 0;
  int n_fail   = 0;

  iexecute dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .flush      (flush),
    .wb_ctl     (wb_ctl),
    .m_ctl      (m_ctl),
    .regdst     (regdst),
    .alusrc     (alusrc),
    .aluop      (aluop),
    .npc        (npc),
    .rdata1     (rdata1),
    .rdata2     (rdata2),
    .s_extend   (s_extend),
    .instr_2016 (instr_2016),
    .instr_1511 (instr_1511),
    .wb_ctlout  (wb_ctlout),
    .branch     (branch),
    .memread    (memread),
    .memwrite   (memwrite),
    .add_result (add_result),
    .zero       (zero),
    .alu_result (alu_result),
    .rdata2out  (rdata2out),
    .muxout     (muxout),
    .pcsrc      (pcsrc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    stall = 0; flush = 0; wb_ctl = 0; m_ctl = 0; regdst = 0; alusrc = 0;
    aluop = 0; npc = 0; rdata1 = 0; rdata2 = 0; s_extend = 0;
    instr_2016 = 0; instr_1511 = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wb"},   32'(wb_ctlout), 32'd0);
    check({tag, "_ctl"},  32'({branch, memread, memwrite, pcsrc, zero}), 32'd0);
    check({tag, "_alu"},  alu_result, 32'd0);
    check({tag, "_tgt"},  add_result, 32'd0);
    check({tag, "_rd2"},  rdata2out, 32'd0);
    check({tag, "_dst"},  32'(muxout), 32'd0);
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    step();
    check_all_zero("por");
    rst_n = 1;

    // R-type add, also used to make outputs nonzero before a mid-run reset
    aluop = 2'b10; s_extend = 32'h20; rdata1 = 5; rdata2 = 7;
    regdst = 1; instr_1511 = 3; wb_ctl = 2'b10; npc = 32'h40;
    step();
    check("radd_alu",  alu_result, 32'd12);
    check("radd_zero", 32'(zero), 32'd0);
    check("radd_dst",  32'(muxout), 32'd3);
    check("radd_wb",   32'(wb_ctlout), 32'd2);
    check("radd_rd2",  rdata2out, 32'd7);
    check("radd_tgt",  add_result, 32'hC0);

    // asynchronous reset mid-cycle
    #2 rst_n = 0;
    #1;
    check_all_zero("arst");
    step();
    check_all_zero("arst_hold");
    rst_n = 1;
    #1;
    check_all_zero("arst_rel");
    step();
    check("arst_load", alu_result, 32'd12);

    // lw address computation
    clear_inputs();
    aluop = 2'b00; alusrc = 1; rdata1 = 32'h100; s_extend = 32'hFFFF_FFFC;
    m_ctl = 3'b010; regdst = 0; instr_2016 = 8; instr_1511 = 21; wb_ctl = 2'b11;
    step();
    check("lw_alu", alu_result, 32'hFC);
    check("lw_mrd", 32'(memread), 32'd1);
    check("lw_ctl", 32'({branch, memwrite, pcsrc}), 32'd0);
    check("lw_dst", 32'(muxout), 32'd8);

    // beq taken
    clear_inputs();
    aluop = 2'b01; m_ctl = 3'b100; rdata1 = 9; rdata2 = 9; npc = 32'h20; s_extend = 3;
    step();
    check("beq_zero",  32'(zero), 32'd1);
    check("beq_pcsrc", 32'(pcsrc), 32'd1);
    check("beq_tgt",   add_result, 32'h2C);
    check("beq_br",    32'(branch), 32'd1);

    // beq not taken
    rdata1 = 32'hFFFF_FFFF; rdata2 = 1;
    step();
    check("bne_pcsrc", 32'(pcsrc), 32'd0);
    check("bne_alu",   alu_result, 32'hFFFF_FFFE);

    // slt signed: -1 < 1
    clear_inputs();
    aluop = 2'b10; s_extend = 32'h2A; rdata1 = 32'hFFFF_FFFF; rdata2 = 1;
    step();
    check("slt_alu", alu_result, 32'd1);
    rdata1 = 1; rdata2 = 32'hFFFF_FFFF;
    step();
    check("slt_rev", alu_result, 32'd0);

    // and / or / sub with branch set but nonzero result
    s_extend = 32'h24; rdata1 = 32'hF0F0_00FF; rdata2 = 32'h0FF0_0F0F;
    step();
    check("and_alu", alu_result, 32'h00F0_000F);
    s_extend = 32'h25;
    step();
    check("or_alu", alu_result, 32'hFFF0_0FFF);
    s_extend = 32'h22; m_ctl = 3'b100; rdata1 = 3; rdata2 = 5;
    step();
    check("sub_alu",   alu_result, 32'hFFFF_FFFE);
    check("sub_pcsrc", 32'(pcsrc), 32'd0);

    // branch target wraps modulo 2^32; memwrite path with store data
    clear_inputs();
    npc = 32'hFFFF_FFFC; s_extend = 1; alusrc = 1; rdata2 = 32'hDEAD_BEEF; m_ctl = 3'b001;
    step();
    check("wrap_tgt", add_result, 32'd0);
    check("sw_mwr",   32'(memwrite), 32'd1);
    check("sw_rd2",   rdata2out, 32'hDEAD_BEEF);

    // known state for the stall test: R-type add 5+7, memread/regwrite set
    clear_inputs();
    aluop = 2'b10; s_extend = 32'h20; rdata1 = 5; rdata2 = 7; regdst = 1;
    instr_1511 = 3; wb_ctl = 2'b10; m_ctl = 3'b010;
    step();
    stall = 1;
    rdata1 = 100; instr_1511 = 9; wb_ctl = 2'b01; m_ctl = 3'b101;
    step();
    check("stall1_alu", alu_result, 32'd12);
    check("stall1_dst", 32'(muxout), 32'd3);
    rdata2 = 1; aluop = 2'b01;
    step();
    check("stall2_alu", alu_result, 32'd12);
    check("stall2_wb",  32'(wb_ctlout), 32'd2);
    check("stall2_mrd", 32'(memread), 32'd1);

    // flush beats stall
    flush = 1;
    step();
    check_all_zero("flush");

    // unknown funct and reserved aluop both pass 0
    clear_inputs();
    aluop = 2'b10; s_extend = 32'h3F; rdata1 = 5; rdata2 = 7; m_ctl = 3'b100;
    step();
    check("unk_alu",   alu_result, 32'd0);
    check("unk_zero",  32'(zero), 32'd1);
    check("unk_pcsrc", 32'(pcsrc), 32'd1);
    aluop = 2'b11; s_extend = 32'h20; m_ctl = 3'b000;
    step();
    check("rsv_alu",  alu_result, 32'd0);
    check("rsv_zero", 32'(zero), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
